// File: rtl/data_bridge_pkg.sv
// Shared types and constants for the CPU data-port to valid/ready bus bridge.
// Contents: FSM state enum, CPU store-size codes (i_memsize), funct3 access-size
// codes (funct3[1:0]) and a misalignment helper used when MISALIGN_TRAP_EN is
// defined at the top level.
package data_bridge_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = DATA_W / 8;
  localparam int unsigned OFF_W  = 2;

  localparam logic [BE_W-1:0] BE_FULL = 4'b1111;
  localparam logic [BE_W-1:0] BE_BYTE = 4'b0001;
  localparam logic [BE_W-1:0] BE_HALF = 4'b0011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // CPU store size (i_memsize); 2'b00 is handled as a word store
  localparam logic [1:0] MS_BYTE = 2'b01;
  localparam logic [1:0] MS_HALF = 2'b10;
  localparam logic [1:0] MS_WORD = 2'b11;

  // Access size carried in funct3[1:0] of loads and stores
  localparam logic [1:0] F3_BYTE = 2'b00;
  localparam logic [1:0] F3_HALF = 2'b01;
  localparam logic [1:0] F3_WORD = 2'b10;

  // True when the access size in funct3 does not fit the low address bits
  function automatic logic is_misaligned(input logic [2:0]       funct3,
                                         input logic [OFF_W-1:0] addr_lo);
    logic mis;
    case (funct3[1:0])
      F3_BYTE: mis = 1'b0;
      F3_HALF: mis = addr_lo[0];
      F3_WORD: mis = (addr_lo != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/data_bridge_lane_align.sv
// Combinational lane steering for the data bridge.
// Ports:
//   we        - current request is a store
//   memsize   - store size code (MS_*)
//   st_offset - byte offset of the incoming request address
//   ld_offset - byte offset captured for the outstanding load
//   wdata     - store data, value in the low lanes
//   rdata     - raw bus read data
//   be_c      - byte enables for the request (all lanes for loads)
//   wdata_c   - lane-replicated store data
//   rdata_c   - read data shifted down so the addressed byte lands in lane 0
module lane_align
  import data_bridge_pkg::*;
(
  input  logic              we,
  input  logic [1:0]        memsize,
  input  logic [OFF_W-1:0]  st_offset,
  input  logic [OFF_W-1:0]  ld_offset,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  output logic [BE_W-1:0]   be_c,
  output logic [DATA_W-1:0] wdata_c,
  output logic [DATA_W-1:0] rdata_c
);

  // Byte enables and store data; lanes shifted past lane 3 are dropped
  always_comb begin
    be_c    = BE_FULL;
    wdata_c = wdata;
    if (we) begin
      case (memsize)
        MS_BYTE: begin
          be_c    = BE_BYTE << st_offset;
          wdata_c = {4{wdata[7:0]}};
        end
        MS_HALF: begin
          be_c    = BE_HALF << st_offset;
          wdata_c = {2{wdata[15:0]}};
        end
        MS_WORD: be_c = BE_FULL << st_offset;
        default: be_c = BE_FULL << st_offset;
      endcase
    end
  end

  // Right-align load data to lane 0
  assign rdata_c = rdata >> {ld_offset, 3'b000};

endmodule

// File: rtl/data_bridge.sv
// Bridge between the single-cycle CPU data port and a valid/ready bus.
// Each CPU load/store becomes one bus transaction; o_hold stalls the CPU until
// the DONE cycle, where it commits using the registered o_rdata.
// Optional feature: define MISALIGN_TRAP_EN to trap misaligned half/word
// accesses (no bus transaction, o_err set, o_rdata cleared).
// Ports:
//   i_clk, i_rst               - clock, synchronous active-high reset
//   i_load, i_write            - CPU request (store wins if both)
//   i_addr, i_wdata            - byte address, store data in low lanes
//   i_memsize, i_funct3        - store size, access size for alignment
//   o_rdata, o_hold, o_err     - load data, CPU stall, sticky error
//   o_bus_valid/addr/we/be/wdata, i_bus_ready - bus request channel
//   i_bus_rvalid, i_bus_rdata  - bus read response
module data_bridge
  import data_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic              i_write,
  input  logic [DATA_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [1:0]        i_memsize,
  input  logic [2:0]        i_funct3,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_hold,
  output logic              o_err,
  output logic              o_bus_valid,
  input  logic              i_bus_ready,
  output logic [DATA_W-1:0] o_bus_addr,
  output logic              o_bus_we,
  output logic [BE_W-1:0]   o_bus_be,
  output logic [DATA_W-1:0] o_bus_wdata,
  input  logic              i_bus_rvalid,
  input  logic [DATA_W-1:0] i_bus_rdata
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [OFF_W-1:0]   offset;
  logic               req_c;
  logic               trap_c;
  logic               timeout_c;
  logic [BE_W-1:0]    be_c;
  logic [DATA_W-1:0]  wdata_c;
  logic [DATA_W-1:0]  rdata_c;

  assign req_c = i_load | i_write;

`ifdef MISALIGN_TRAP_EN
  assign trap_c = is_misaligned(i_funct3, i_addr[OFF_W-1:0]);
`else
  logic unused_funct3_c;
  assign trap_c          = 1'b0;
  assign unused_funct3_c = ^i_funct3;
`endif

  // Last permitted wait cycle across ADDR and RESP combined
  assign timeout_c = ((state == ST_ADDR) || (state == ST_RESP)) &&
                     (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  lane_align u_lane_align (
    .we        (i_write),
    .memsize   (i_memsize),
    .st_offset (i_addr[OFF_W-1:0]),
    .ld_offset (offset),
    .wdata     (i_wdata),
    .rdata     (i_bus_rdata),
    .be_c      (be_c),
    .wdata_c   (wdata_c),
    .rdata_c   (rdata_c)
  );

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and CPU hold; a completing handshake wins over the timeout
  always_comb begin
    state_nxt = state;
    o_hold    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_c) begin
          o_hold    = 1'b1;
          state_nxt = trap_c ? ST_DONE : ST_ADDR;
        end
      end
      ST_ADDR: begin
        o_hold = 1'b1;
        if (i_bus_ready) begin
          state_nxt = o_bus_we ? ST_DONE : ST_RESP;
        end else if (timeout_c) begin
          state_nxt = ST_DONE;
        end
      end
      ST_RESP: begin
        o_hold = 1'b1;
        if (i_bus_rvalid || timeout_c) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Request capture, bus outputs, load data, timeout counter and error flag
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt         <= '0;
      offset      <= '0;
      o_err       <= 1'b0;
      o_rdata     <= '0;
      o_bus_valid <= 1'b0;
      o_bus_we    <= 1'b0;
      o_bus_be    <= '0;
      o_bus_addr  <= '0;
      o_bus_wdata <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_c) begin
            cnt    <= '0;
            offset <= i_addr[OFF_W-1:0];
            if (trap_c) begin
              o_err   <= 1'b1;
              o_rdata <= '0;
            end else begin
              o_bus_valid <= 1'b1;
              o_bus_we    <= i_write;
              o_bus_be    <= be_c;
              o_bus_addr  <= {i_addr[DATA_W-1:2], 2'b00};
              o_bus_wdata <= wdata_c;
            end
          end
        end
        ST_ADDR: begin
          cnt <= cnt + CNT_W'(1);
          if (i_bus_ready) begin
            o_bus_valid <= 1'b0;
          end else if (timeout_c) begin
            o_bus_valid <= 1'b0;
            o_err       <= 1'b1;
            o_rdata     <= '0;
          end
        end
        ST_RESP: begin
          cnt <= cnt + CNT_W'(1);
          if (i_bus_rvalid) begin
            o_rdata <= rdata_c;
          end else if (timeout_c) begin
            o_err   <= 1'b1;
            o_rdata <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_data_bridge.sv
// Scoreboard bench for data_bridge: a stimulus process issues CPU requests and
// pushes expected bus requests and commit results, a bus responder serves
// planned ready/rvalid delays, and a monitor compares on every bus-valid cycle
// and every CPU commit.
`timescale 1ns/1ps
module tb_data_bridge;

  localparam int TO = 8;

`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_load;
  logic        i_write;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic [1:0]  i_memsize;
  logic [2:0]  i_funct3;
  logic [31:0] o_rdata;
  logic        o_hold;
  logic        o_err;
  logic        o_bus_valid;
  logic        i_bus_ready;
  logic [31:0] o_bus_addr;
  logic        o_bus_we;
  logic [3:0]  o_bus_be;
  logic [31:0] o_bus_wdata;
  logic        i_bus_rvalid;
  logic [31:0] i_bus_rdata;

  always #5 i_clk = ~i_clk;

  data_bridge #(.TIMEOUT_CYCLES(TO)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_load       (i_load),
    .i_write      (i_write),
    .i_addr       (i_addr),
    .i_wdata      (i_wdata),
    .i_memsize    (i_memsize),
    .i_funct3     (i_funct3),
    .o_rdata      (o_rdata),
    .o_hold       (o_hold),
    .o_err        (o_err),
    .o_bus_valid  (o_bus_valid),
    .i_bus_ready  (i_bus_ready),
    .o_bus_addr   (o_bus_addr),
    .o_bus_we     (o_bus_we),
    .o_bus_be     (o_bus_be),
    .o_bus_wdata  (o_bus_wdata),
    .i_bus_rvalid (i_bus_rvalid),
    .i_bus_rdata  (i_bus_rdata)
  );

  typedef struct {
    int          id;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        chk_wdata;
  } bus_exp_t;

  typedef struct {
    int          id;
    logic        exp_accept;
    int          hold_cycles;
    logic        chk_rdata;
    logic [31:0] rdata;
    logic        err;
  } done_exp_t;

  typedef struct {
    int          ready_dly;
    int          rvalid_dly;
    logic [31:0] rdata;
    logic        is_load;
  } plan_t;

  bus_exp_t  bus_q[$];
  done_exp_t done_q[$];
  plan_t     plan_q[$];

  int   checks = 0;
  int   passed = 0;
  int   txn_id = 0;
  logic err_model = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: byte-by-byte view of the lanes
  function automatic int size_bytes(input logic [1:0] ms);
    if (ms == 2'b01) return 1;
    if (ms == 2'b10) return 2;
    return 4;
  endfunction

  function automatic void ref_store(input logic [1:0] off, input logic [1:0] ms,
                                    input logic [31:0] wd,
                                    output logic [3:0] be, output logic [31:0] data);
    int nb;
    nb   = size_bytes(ms);
    be   = 4'b0000;
    data = 32'h0;
    for (int i = 0; i < nb; i++)
      if (int'(off) + i < 4) be[int'(off) + i] = 1'b1;
    for (int l = 0; l < 4; l++)
      data[8*l +: 8] = wd[8*(l % nb) +: 8];
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] off, input logic [31:0] rd);
    logic [31:0] res;
    res = 32'h0;
    for (int i = 0; i < 4; i++)
      if (int'(off) + i < 4) res[8*i +: 8] = rd[8*(int'(off) + i) +: 8];
    return res;
  endfunction

  // Halves and words must sit on their natural size boundary
  function automatic bit ref_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    int sz;
    sz = 1 << int'(f3[1:0]);
    return (int'(lo) % sz) != 0;
  endfunction

  task automatic wait_commit(input string name);
    bit got;
    got = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge i_clk);
      if (!o_hold) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++;
      $display("FAIL %s: no commit within 100 cycles, hold=%0b", name, o_hold);
    end
  endtask

  task automatic run_txn(input logic ld, input logic wr, input logic [31:0] addr,
                         input logic [1:0] ms, input logic [2:0] f3,
                         input logic [31:0] wd, input int rdly, input int vdly,
                         input logic [31:0] rd);
    bus_exp_t  b;
    done_exp_t d;
    plan_t     p;
    int        waited;
    bit        trap;
    @(posedge i_clk); #1;
    txn_id++;
    trap = TRAP_EN && ref_misaligned(f3, addr[1:0]);
    d.id = txn_id;
    if (trap) begin
      err_model    = 1'b1;
      d.exp_accept = 1'b0;
      d.hold_cycles = 1;
      d.chk_rdata  = 1'b1;
      d.rdata      = 32'h0;
    end else begin
      b.id   = txn_id;
      b.addr = {addr[31:2], 2'b00};
      b.we   = wr;
      if (wr) begin
        ref_store(addr[1:0], ms, wd, b.be, b.wdata);
        b.chk_wdata = 1'b1;
      end else begin
        b.be        = 4'b1111;
        b.wdata     = 32'h0;
        b.chk_wdata = 1'b0;
      end
      bus_q.push_back(b);
      waited       = wr ? rdly + 1 : rdly + vdly + 2;
      d.exp_accept = (rdly + 1 <= TO);
      if (waited > TO || rdly + 1 > TO) begin
        err_model     = 1'b1;
        d.hold_cycles = 1 + TO;
        d.chk_rdata   = 1'b1;
        d.rdata       = 32'h0;
      end else begin
        d.hold_cycles = 1 + waited;
        d.chk_rdata   = !wr;
        d.rdata       = wr ? 32'h0 : ref_load(addr[1:0], rd);
      end
      p.ready_dly  = rdly;
      p.rvalid_dly = vdly;
      p.rdata      = rd;
      p.is_load    = !wr;
      plan_q.push_back(p);
    end
    d.err = err_model;
    done_q.push_back(d);
    i_load    = ld;
    i_write   = wr;
    i_addr    = addr;
    i_wdata   = wd;
    i_memsize = ms;
    i_funct3  = f3;
    wait_commit("commit_wait");
    @(posedge i_clk); #1;
    i_load  = 1'b0;
    i_write = 1'b0;
  endtask

  // Bus responder: serves one plan entry per presented request
  initial begin : responder
    plan_t p;
    bit    got;
    i_bus_ready  = 1'b0;
    i_bus_rvalid = 1'b0;
    i_bus_rdata  = 32'h0;
    forever begin
      @(negedge i_clk);
      if (o_bus_valid && plan_q.size() != 0) begin
        p   = plan_q.pop_front();
        got = 1'b0;
        for (int c = 0; c < 64 && o_bus_valid; c++) begin
          if (c == p.ready_dly) begin
            i_bus_ready = 1'b1;
            @(negedge i_clk);
            i_bus_ready = 1'b0;
            got = 1'b1;
            break;
          end
          @(negedge i_clk);
        end
        if (got && p.is_load) begin
          repeat (p.rvalid_dly) @(negedge i_clk);
          i_bus_rvalid = 1'b1;
          i_bus_rdata  = p.rdata;
          @(negedge i_clk);
          i_bus_rvalid = 1'b0;
          i_bus_rdata  = $urandom();
        end
      end
    end
  end

  // Monitor: bus request fields every valid cycle, results at every commit
  initial begin : monitor
    int        hold_cnt;
    logic      accepted;
    bus_exp_t  b;
    done_exp_t d;
    hold_cnt = 0;
    accepted = 1'b0;
    forever begin
      @(negedge i_clk);
      if (i_rst) begin
        hold_cnt = 0;
        accepted = 1'b0;
        continue;
      end
      if (o_hold) hold_cnt++;
      if (o_bus_valid) begin
        if (bus_q.size() == 0) begin
          checks++;
          $display("FAIL bus_unexpected: valid=1 addr=0x%08h expected no request", o_bus_addr);
        end else begin
          b = bus_q[0];
          chk("bus_addr", o_bus_addr, b.addr);
          chk("bus_we", 32'(o_bus_we), 32'(b.we));
          chk("bus_be", 32'(o_bus_be), 32'(b.be));
          if (b.chk_wdata) chk("bus_wdata", o_bus_wdata, b.wdata);
          if (i_bus_ready) begin
            void'(bus_q.pop_front());
            accepted = 1'b1;
          end
        end
      end
      if ((i_load || i_write) && !o_hold) begin
        if (done_q.size() == 0) begin
          checks++;
          $display("FAIL commit_unexpected: commit seen, expected none");
        end else begin
          d = done_q.pop_front();
          chk("hold_cycles", 32'(hold_cnt), 32'(d.hold_cycles));
          chk("bus_accepted", 32'(accepted), 32'(d.exp_accept));
          chk("err", 32'(o_err), 32'(d.err));
          if (d.chk_rdata) chk("rdata", o_rdata, d.rdata);
          if (!accepted && bus_q.size() != 0 && bus_q[0].id == d.id)
            void'(bus_q.pop_front());
        end
        hold_cnt = 0;
        accepted = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : stimulus
    bus_exp_t    b;
    plan_t       p;
    logic [31:0] a, wd, rd;
    logic [1:0]  ms;
    logic [2:0]  f3;
    logic        ld, wr;
    int          rdly, vdly, kind;

    i_rst = 1'b1; i_load = 1'b0; i_write = 1'b0; i_addr = 32'h0;
    i_wdata = 32'h0; i_memsize = 2'b00; i_funct3 = 3'b000;
    repeat (3) @(posedge i_clk);
    #1 i_rst = 1'b0;
    @(negedge i_clk);
    chk("reset_hold", 32'(o_hold), 32'h0);
    chk("reset_valid", 32'(o_bus_valid), 32'h0);
    chk("reset_err", 32'(o_err), 32'h0);
    chk("reset_rdata", o_rdata, 32'h0);
    chk("reset_bus_be", 32'(o_bus_be), 32'h0);
    chk("reset_bus_addr", o_bus_addr, 32'h0);

    // Byte store at 0x1003, zero-wait bus
    run_txn(1'b0, 1'b1, 32'h0000_1003, 2'b01, 3'b000, 32'h0000_00A5, 0, 0, 32'h0);
    // Half load (lhu) at 0x2002, zero-wait bus
    run_txn(1'b1, 1'b0, 32'h0000_2002, 2'b11, 3'b101, 32'h0, 0, 0, 32'h1122_3344);
    // Word load with ready delayed 3 and rvalid delayed 2
    run_txn(1'b1, 1'b0, 32'h0000_3000, 2'b11, 3'b010, 32'h0, 3, 2, 32'hA1B2_C3D4);
    // Bus never ready: abort after TO cycles
    run_txn(1'b1, 1'b0, 32'h0000_4000, 2'b11, 3'b010, 32'h0, 100, 0, 32'h5555_AAAA);
    // Next request proceeds normally with the error still latched
    run_txn(1'b0, 1'b1, 32'h0000_5004, 2'b11, 3'b010, 32'hDEAD_BEEF, 1, 0, 32'h0);

    // Reset while waiting in RESP; rvalid arrives afterwards
    @(posedge i_clk); #1;
    txn_id++;
    b.id = txn_id; b.addr = 32'h0000_8000; b.we = 1'b0; b.be = 4'b1111;
    b.wdata = 32'h0; b.chk_wdata = 1'b0;
    bus_q.push_back(b);
    p.ready_dly = 0; p.rvalid_dly = 5; p.rdata = 32'h9988_7766; p.is_load = 1'b1;
    plan_q.push_back(p);
    i_load = 1'b1; i_write = 1'b0; i_addr = 32'h0000_8000; i_funct3 = 3'b010;
    repeat (3) @(negedge i_clk);
    chk("resp_hold", 32'(o_hold), 32'h1);
    chk("resp_valid", 32'(o_bus_valid), 32'h0);
    @(posedge i_clk); #1;
    i_rst = 1'b1; i_load = 1'b0;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    err_model = 1'b0;
    @(negedge i_clk);
    chk("post_rst_valid", 32'(o_bus_valid), 32'h0);
    chk("post_rst_err", 32'(o_err), 32'h0);
    chk("post_rst_rdata", o_rdata, 32'h0);
    chk("post_rst_hold", 32'(o_hold), 32'h0);
    repeat (6) @(negedge i_clk);
    chk("late_rvalid_rdata", o_rdata, 32'h0);
    chk("late_rvalid_hold", 32'(o_hold), 32'h0);

    // Word store at 0x1002: trapped, or upper lanes only
    run_txn(1'b0, 1'b1, 32'h0000_1002, 2'b11, 3'b010, 32'hCAFE_F00D, 0, 0, 32'h0);
    // Load and store together: the store wins
    run_txn(1'b1, 1'b1, 32'h0000_6002, 2'b10, 3'b001, 32'h0000_BEEF, 1, 0, 32'h0);
    // Size code 00 behaves as a word store
    run_txn(1'b0, 1'b1, 32'h0000_7000, 2'b00, 3'b010, 32'h0123_4567, 0, 0, 32'h0);

    for (int n = 0; n < 40; n++) begin
      kind = int'($urandom_range(0, 3));
      a    = $urandom();
      wd   = $urandom();
      rd   = $urandom();
      ms   = 2'($urandom_range(0, 3));
      rdly = ($urandom_range(0, 9) == 0) ? 12 : int'($urandom_range(0, 3));
      vdly = int'($urandom_range(0, 2));
      wr   = (kind >= 2);
      ld   = (kind != 2);
      if (wr) begin
        f3 = (ms == 2'b01) ? 3'b000 : (ms == 2'b10) ? 3'b001 : 3'b010;
      end else begin
        case ($urandom_range(0, 4))
          0: f3 = 3'b000;
          1: f3 = 3'b001;
          2: f3 = 3'b010;
          3: f3 = 3'b100;
          default: f3 = 3'b101;
        endcase
      end
      run_txn(ld, wr, a, ms, f3, wd, rdly, vdly, rd);
      repeat ($urandom_range(0, 2)) @(posedge i_clk);
    end

    repeat (5) @(negedge i_clk);
    chk("done_q_drained", 32'(done_q.size()), 32'h0);
    chk("bus_q_drained", 32'(bus_q.size()), 32'h0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
